spi_frame_writer: RTL and testbench
===================================

Name: spi_frame_writer

Overview:
- SPI mode-0 slave: receives pixel bytes from the MCU and writes them into the back half of the double-buffered matrix frame RAM.
- It is the writer side of the frame buffer; the matrix scanner is the reader.
- Tracks the display/back buffer index and swaps buffers only at a scanner frame boundary.
- Write address generation uses an internal up-counter.

Parameters:
- ADDR_W, 10, pixel address width; frame depth DEPTH = 2**ADDR_W.
- PIX_W, 6, pixel width in bits (r1 g1 b1 r2 g2 b2); legal range 1..8.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- sck  in  1  SPI clock, asynchronous, at most clk/4
- sdi  in  1  SPI data in, MSB first
- cs_n  in  1  SPI chip select, active-low, asynchronous
- sdo  out  1  SPI data out (see Optional Feature)
- rd_vsync  in  1  one-cycle pulse from the scanner at its frame boundary
- we  out  1  frame RAM write strobe, one clk wide
- waddr  out  ADDR_W  frame RAM write address
- wdata  out  PIX_W  frame RAM write data
- wbuf  out  1  buffer being written; always equals ~disp_buf
- disp_buf  out  1  buffer the scanner reads
- busy  out  1  high in HOLD state
- ovf  out  1  sticky error flag

Behaviour:
- Input sync: sck, sdi, cs_n each pass through 2 flops. Reset values are sck 0, sdi 0, cs_n 1.
- Edge detect in the clk domain: sck rise = sync 0->1; cs fall = sync 1->0.
- Reset values: we 0, waddr 0, wdata 0, disp_buf 0, busy 0, ovf 0, sdo 0, bit count 0, shift register 0, state IDLE.
- States:
  - IDLE -> RECV on cs fall. Bit count and address are cleared on entry.
  - RECV: on each sck rise, shift in sdi (MSB first) and increment the 3-bit bit count.
  - RECV, 8th bit: on the clk after the 8th rise, assert we for 1 cycle with wdata = byte[PIX_W-1:0] and waddr = current address. The address increments the cycle after we.
  - RECV -> HOLD in the cycle the write to address DEPTH-1 is issued. The transition happens regardless of cs_n.
  - RECV -> IDLE if cs_n is seen high before the frame completes (abort).
    - Address returns to 0 and there is no swap.
    - Partial back-buffer data remains in RAM.
    - A partial byte (bit count not 0) is discarded.
  - HOLD: busy = 1 and all SPI activity is ignored (no we).
    - A completed byte received in HOLD sets ovf.
    - On rd_vsync: toggle disp_buf, go to IDLE, busy = 0.
  - HOLD -> IDLE also requires no pending cs: if cs_n is still low at the swap, stay in IDLE until a fresh cs fall.
- Simultaneous events:
  - rd_vsync in the same cycle as the RECV->HOLD transition is ignored; the block waits for the next vsync.
  - rd_vsync outside HOLD has no effect.
- ovf: sticky; cleared only by reset.
- Reset mid-transaction:
  - All state returns to reset values.
  - Because cs_n sync resets to 1, a cs_n that is already low registers as a cs fall. The block therefore enters RECV mid-byte and writes misaligned data.
  - The MCU must deassert cs_n across a controller reset; the bench checks only state, not data alignment.
- Latency: the we cycle is 4 clk cycles after the 8th raw sck rising edge (2 sync + edge detect + register), ±1 for async sampling.

Optional Feature:
- Macro: SPI_ECHO_EN.
- Defined: sdo shifts out the previously received complete byte, MSB first.
  - It updates on the clk after each sck falling edge is detected.
  - The echo byte is loaded at every byte boundary.
  - The first byte of a transaction echoes 0x00.
  - sdo = 0 whenever cs_n is high.
- Undefined: sdo tied 0 and no echo register is synthesised.

Test Plan:
- Full frame, ADDR_W=2, PIX_W=6, send 0x01 0x02 0x03 0x3F -> four we pulses, waddr 0..3, wdata 01,02,03,3F, wbuf=1. Then busy=1; after an rd_vsync pulse, disp_buf=1, wbuf=0, busy=0.
- Abort: send 2 bytes then cs_n high -> 2 writes, state IDLE, waddr back to 0 on the next frame, disp_buf unchanged at 0. Next full frame starts at address 0.
- HOLD overrun: after 4 bytes, send 0xAA in the same transaction without vsync -> no we, ovf=1. Then reset -> ovf=0, disp_buf=0.
- Vsync coincident with the last write -> no swap. Second vsync 10 cycles later -> disp_buf toggles.
- Partial byte: 5 sck bits then cs_n high -> no we, and the next transaction's first full byte lands at address 0 intact.
- SPI_ECHO_EN: send 0xA5 then 0x3C -> sdo bits during the second byte are 1,0,1,0,0,1,0,1.

Source files
------------

// File: rtl/spi_frame_writer.sv
`default_nettype none
// ============================================================================
// Module      : spi_frame_writer
// Description : SPI mode-0 slave that writes pixel bytes into the back half of
//               a double-buffered frame RAM and swaps buffers on rd_vsync.
//               Optional macro SPI_ECHO_EN echoes the previous byte on sdo.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_frame_writer #(
    parameter int ADDR_W = 10,
    parameter int PIX_W  = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sck,
    input  logic              sdi,
    input  logic              cs_n,
    output logic              sdo,
    input  logic              rd_vsync,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [PIX_W-1:0]  wdata,
    output logic              wbuf,
    output logic              disp_buf,
    output logic              busy,
    output logic              ovf
);

    localparam logic [ADDR_W-1:0] c_last_addr = {ADDR_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RECV = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [1:0]        r_sck_s;
    logic [1:0]        r_sdi_s;
    logic [1:0]        r_cs_s;
    logic              r_sck_d;
    logic              r_cs_d;
    logic [2:0]        r_bitcnt;
    logic [PIX_W-1:0]  r_shift;
    logic [PIX_W-1:0]  w_shift_next;
    logic              r_pending;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [PIX_W-1:0]  r_wdata;
    logic              r_disp;
    logic              r_ovf;

    logic w_sck_rise;
    logic w_cs_fall;
    logic w_cs_high;
    logic w_active;
    logic w_rise_last;
    logic w_last_wr;
    logic w_we_next;
    logic w_addr_clr;
    logic w_swap;

    assign w_sck_rise  = r_sck_s[1] & ~r_sck_d;
    assign w_cs_fall   = r_cs_d & ~r_cs_s[1];
    assign w_cs_high   = r_cs_s[1];
    assign w_active    = (r_state != ST_IDLE);
    assign w_rise_last = w_sck_rise & (r_bitcnt == 3'd7) & w_active;
    assign w_last_wr   = r_we & (r_addr == c_last_addr);

    // Only the low PIX_W bits of each byte are kept; MSB-first order means
    // they are simply the last PIX_W bits shifted in.
    generate
        if (PIX_W == 1) begin : g_shift_w1
            assign w_shift_next = r_sdi_s[1];
        end else begin : g_shift_wn
            assign w_shift_next = {r_shift[PIX_W-2:0], r_sdi_s[1]};
        end
    endgenerate

    always_comb begin
        w_state_next = r_state;
        w_we_next    = 1'b0;
        w_addr_clr   = 1'b0;
        w_swap       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_cs_fall) begin
                    w_state_next = ST_RECV;
                    w_addr_clr   = 1'b1;
                end
            end
            ST_RECV: begin
                // Frame completes at the end of the last write cycle, so a
                // vsync coincident with that write is ignored.
                if (w_last_wr) begin
                    w_state_next = ST_HOLD;
                end else begin
                    w_we_next = r_pending;
                    if (w_cs_high && !r_pending && !w_rise_last && !r_we) begin
                        w_state_next = ST_IDLE;
                        w_addr_clr   = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (rd_vsync) begin
                    w_state_next = ST_IDLE;
                    w_swap       = 1'b1;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_sck_s   <= 2'b00;
            r_sdi_s   <= 2'b00;
            r_cs_s    <= 2'b11;
            r_sck_d   <= 1'b0;
            r_cs_d    <= 1'b1;
            r_bitcnt  <= 3'd0;
            r_shift   <= '0;
            r_pending <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_disp    <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_sck_s   <= {r_sck_s[0], sck};
            r_sdi_s   <= {r_sdi_s[0], sdi};
            r_cs_s    <= {r_cs_s[0], cs_n};
            r_sck_d   <= r_sck_s[1];
            r_cs_d    <= r_cs_s[1];
            r_pending <= w_rise_last;
            r_we      <= w_we_next;

            if (w_cs_high || w_addr_clr) begin
                r_bitcnt <= 3'd0;
            end else if (w_sck_rise && w_active) begin
                r_bitcnt <= r_bitcnt + 3'd1;
            end

            if (w_sck_rise && w_active) begin
                r_shift <= w_shift_next;
            end

            if (w_we_next) begin
                r_wdata <= r_shift;
            end

            if (w_addr_clr) begin
                r_addr <= '0;
            end else if (r_we) begin
                r_addr <= r_addr + ADDR_W'(1);
            end

            if (w_swap) begin
                r_disp <= ~r_disp;
            end

            if ((r_state == ST_HOLD) && r_pending) begin
                r_ovf <= 1'b1;
            end
        end
    end

`ifdef SPI_ECHO_EN
    logic [7:0] r_rx8;
    logic [7:0] r_echo;
    logic [7:0] r_tx;
    logic       r_sdo;
    logic       w_sck_fall;

    assign w_sck_fall = r_sck_d & ~r_sck_s[1];

    // The falling edge right after a byte boundary presents the MSB of the
    // byte just captured; other falling edges advance the echo shifter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx8  <= 8'h00;
            r_echo <= 8'h00;
            r_tx   <= 8'h00;
            r_sdo  <= 1'b0;
        end else if (w_cs_high || w_cs_fall) begin
            r_echo <= 8'h00;
            r_tx   <= 8'h00;
            r_sdo  <= 1'b0;
        end else begin
            if (w_sck_rise) begin
                r_rx8 <= {r_rx8[6:0], r_sdi_s[1]};
            end
            if (r_pending) begin
                r_echo <= r_rx8;
            end
            if (w_sck_fall) begin
                if (r_bitcnt == 3'd0) begin
                    r_sdo <= r_echo[7];
                    r_tx  <= {r_echo[6:0], 1'b0};
                end else begin
                    r_sdo <= r_tx[7];
                    r_tx  <= {r_tx[6:0], 1'b0};
                end
            end
        end
    end

    assign sdo = r_sdo;
`else
    assign sdo = 1'b0;
`endif

    assign we       = r_we;
    assign waddr    = r_addr;
    assign wdata    = r_wdata;
    assign disp_buf = r_disp;
    assign wbuf     = ~r_disp;
    assign busy     = (r_state == ST_HOLD);
    assign ovf      = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_spi_frame_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_frame_writer
// Description : Directed self-checking bench for spi_frame_writer (ADDR_W=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_frame_writer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       sck = 1'b0;
    logic       sdi = 1'b0;
    logic       cs_n = 1'b1;
    logic       sdo;
    logic       rd_vsync = 1'b0;
    logic       we;
    logic [1:0] waddr;
    logic [5:0] wdata;
    logic       wbuf;
    logic       disp_buf;
    logic       busy;
    logic       ovf;

    int errors = 0;
    int checks = 0;

    int         wr_cnt = 0;
    logic [1:0] wr_addr [0:63];
    logic [5:0] wr_data [0:63];
    logic       wr_buf  [0:63];

    spi_frame_writer #(.ADDR_W(2), .PIX_W(6)) dut (
        .clk      (clk),
        .reset    (reset),
        .sck      (sck),
        .sdi      (sdi),
        .cs_n     (cs_n),
        .sdo      (sdo),
        .rd_vsync (rd_vsync),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .wbuf     (wbuf),
        .disp_buf (disp_buf),
        .busy     (busy),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (we && wr_cnt < 64) begin
            wr_addr[wr_cnt] <= waddr;
            wr_data[wr_cnt] <= wdata;
            wr_buf[wr_cnt]  <= wbuf;
        end
        if (we) wr_cnt <= wr_cnt + 1;
    end

    task automatic do_reset();
        cs_n = 1'b1;
        sck  = 1'b0;
        sdi  = 1'b0;
        rd_vsync = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic cs_begin();
        @(negedge clk);
        cs_n = 1'b0;
        #80;
    endtask

    task automatic cs_end();
        #80;
        cs_n = 1'b1;
        #80;
    endtask

    // sck is half-period 40 ns (clk/8); sdo is sampled at each rising sck.
    task automatic spi_bits(input logic [7:0] b, input int nbits, output logic [7:0] echo);
        echo = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            sdi = b[i];
            #40;
            sck = 1'b1;
            echo[i] = sdo;
            #40;
            sck = 1'b0;
        end
    endtask

    task automatic pulse_vsync();
        @(negedge clk);
        rd_vsync = 1'b1;
        @(negedge clk);
        rd_vsync = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [7:0] junk;
        do_reset();
        checks++; if (we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", we); end
        checks++; if (waddr !== 2'd0) begin errors++; $display("FAIL reset_waddr: got %0d want 0", waddr); end
        checks++; if (wdata !== 6'd0) begin errors++; $display("FAIL reset_wdata: got %h want 00", wdata); end
        checks++; if (disp_buf !== 1'b0) begin errors++; $display("FAIL reset_disp_buf: got %b want 0", disp_buf); end
        checks++; if (wbuf !== 1'b1) begin errors++; $display("FAIL reset_wbuf: got %b want 1", wbuf); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", ovf); end
        checks++; if (sdo !== 1'b0) begin errors++; $display("FAIL reset_sdo: got %b want 0", sdo); end
        // sck toggling while cs_n is high must not write anything
        spi_bits(8'hFF, 8, junk);
        repeat (8) @(negedge clk);
        checks++; if (wr_cnt !== 0) begin errors++; $display("FAIL idle_no_write: got %0d writes want 0", wr_cnt); end
    endtask

    task automatic test_full_frame();
        logic [7:0] bytes [0:3];
        logic [7:0] junk;
        int base;
        bytes[0] = 8'h01; bytes[1] = 8'h02; bytes[2] = 8'h03; bytes[3] = 8'h3F;
        do_reset();
        base = wr_cnt;
        cs_begin();
        for (int k = 0; k < 4; k++) spi_bits(bytes[k], 8, junk);
        repeat (8) @(negedge clk);
        checks++; if (wr_cnt - base !== 4) begin errors++; $display("FAIL frame_count: got %0d want 4", wr_cnt - base); end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (wr_addr[base+k] !== 2'(k) || wr_data[base+k] !== bytes[k][5:0] || wr_buf[base+k] !== 1'b1) begin
                errors++;
                $display("FAIL frame_write%0d: got addr=%0d data=%h wbuf=%b want addr=%0d data=%h wbuf=1",
                         k, wr_addr[base+k], wr_data[base+k], wr_buf[base+k], k, bytes[k][5:0]);
            end
        end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL frame_busy: got %b want 1", busy); end
        cs_end();
        pulse_vsync();
        checks++; if (disp_buf !== 1'b1) begin errors++; $display("FAIL swap_disp_buf: got %b want 1", disp_buf); end
        checks++; if (wbuf !== 1'b0) begin errors++; $display("FAIL swap_wbuf: got %b want 0", wbuf); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL swap_busy: got %b want 0", busy); end
    endtask

    task automatic test_abort();
        logic [7:0] junk;
        int base;
        do_reset();
        base = wr_cnt;
        cs_begin();
        spi_bits(8'h11, 8, junk);
        spi_bits(8'h22, 8, junk);
        cs_end();
        repeat (4) @(negedge clk);
        checks++;
        if (wr_cnt - base !== 2 || wr_addr[base] !== 2'd0 || wr_data[base] !== 6'h11 ||
            wr_addr[base+1] !== 2'd1 || wr_data[base+1] !== 6'h22) begin
            errors++;
            $display("FAIL abort_writes: got n=%0d a0=%0d d0=%h a1=%0d d1=%h want n=2 a0=0 d0=11 a1=1 d1=22",
                     wr_cnt - base, wr_addr[base], wr_data[base], wr_addr[base+1], wr_data[base+1]);
        end
        checks++; if (waddr !== 2'd0) begin errors++; $display("FAIL abort_waddr: got %0d want 0", waddr); end
        checks++; if (busy !== 1'b0 || disp_buf !== 1'b0) begin errors++; $display("FAIL abort_state: got busy=%b disp=%b want 0 0", busy, disp_buf); end
        base = wr_cnt;
        cs_begin();
        spi_bits(8'h05, 8, junk);
        spi_bits(8'h06, 8, junk);
        spi_bits(8'h07, 8, junk);
        spi_bits(8'h08, 8, junk);
        repeat (8) @(negedge clk);
        checks++;
        if (wr_cnt - base !== 4 || wr_addr[base] !== 2'd0 || wr_data[base] !== 6'h05 ||
            wr_addr[base+3] !== 2'd3 || wr_data[base+3] !== 6'h08) begin
            errors++;
            $display("FAIL abort_next_frame: got n=%0d a0=%0d d0=%h a3=%0d d3=%h want n=4 a0=0 d0=05 a3=3 d3=08",
                     wr_cnt - base, wr_addr[base], wr_data[base], wr_addr[base+3], wr_data[base+3]);
        end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_next_busy: got %b want 1", busy); end
        cs_end();
    endtask

    task automatic test_overrun();
        logic [7:0] junk;
        int base;
        do_reset();
        base = wr_cnt;
        cs_begin();
        for (int k = 0; k < 4; k++) spi_bits(8'h10 + 8'(k), 8, junk);
        spi_bits(8'hAA, 8, junk);
        repeat (8) @(negedge clk);
        checks++; if (wr_cnt - base !== 4) begin errors++; $display("FAIL overrun_count: got %0d want 4", wr_cnt - base); end
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL overrun_ovf: got %b want 1", ovf); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL overrun_busy: got %b want 1", busy); end
        cs_end();
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", ovf); end
        do_reset();
        checks++; if (ovf !== 1'b0 || disp_buf !== 1'b0) begin errors++; $display("FAIL overrun_reset: got ovf=%b disp=%b want 0 0", ovf, disp_buf); end
    endtask

    task automatic test_vsync_coincident();
        logic [7:0] junk;
        logic found;
        do_reset();
        found = 1'b0;
        cs_begin();
        for (int k = 0; k < 3; k++) spi_bits(8'h20 + 8'(k), 8, junk);
        fork
            spi_bits(8'h23, 8, junk);
            begin
                for (int n = 0; n < 2000 && !found; n++) begin
                    @(negedge clk);
                    if (we === 1'b1 && waddr === 2'd3) found = 1'b1;
                end
                if (found) begin
                    rd_vsync = 1'b1;
                    @(negedge clk);
                    rd_vsync = 1'b0;
                end
            end
        join
        checks++; if (found !== 1'b1) begin errors++; $display("FAIL coinc_last_write: got timeout want write to addr 3"); end
        cs_end();
        repeat (10) @(negedge clk);
        checks++; if (disp_buf !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL coinc_no_swap: got disp=%b busy=%b want 0 1", disp_buf, busy); end
        pulse_vsync();
        checks++; if (disp_buf !== 1'b1 || busy !== 1'b0 || wbuf !== 1'b0) begin errors++; $display("FAIL coinc_second_swap: got disp=%b busy=%b wbuf=%b want 1 0 0", disp_buf, busy, wbuf); end
        // vsync outside HOLD does nothing
        pulse_vsync();
        checks++; if (disp_buf !== 1'b1) begin errors++; $display("FAIL idle_vsync: got disp=%b want 1", disp_buf); end
    endtask

    task automatic test_partial();
        logic [7:0] junk;
        int base;
        do_reset();
        base = wr_cnt;
        cs_begin();
        spi_bits(8'hB0, 5, junk);
        cs_end();
        repeat (4) @(negedge clk);
        checks++; if (wr_cnt - base !== 0) begin errors++; $display("FAIL partial_no_we: got %0d writes want 0", wr_cnt - base); end
        cs_begin();
        spi_bits(8'h2A, 8, junk);
        cs_end();
        repeat (4) @(negedge clk);
        checks++;
        if (wr_cnt - base !== 1 || wr_addr[base] !== 2'd0 || wr_data[base] !== 6'h2A) begin
            errors++;
            $display("FAIL partial_next_byte: got n=%0d addr=%0d data=%h want n=1 addr=0 data=2A",
                     wr_cnt - base, wr_addr[base], wr_data[base]);
        end
        checks++; if (waddr !== 2'd0 || busy !== 1'b0) begin errors++; $display("FAIL partial_state: got waddr=%0d busy=%b want 0 0", waddr, busy); end
    endtask

`ifdef SPI_ECHO_EN
    task automatic test_echo();
        logic [7:0] e1;
        logic [7:0] e2;
        do_reset();
        cs_begin();
        spi_bits(8'hA5, 8, e1);
        spi_bits(8'h3C, 8, e2);
        cs_end();
        checks++; if (e1 !== 8'h00) begin errors++; $display("FAIL echo_first: got %h want 00", e1); end
        checks++; if (e2 !== 8'hA5) begin errors++; $display("FAIL echo_second: got %h want A5", e2); end
        checks++; if (sdo !== 1'b0) begin errors++; $display("FAIL echo_cs_high: got %b want 0", sdo); end
    endtask
`endif

    initial begin
        test_reset();
        test_full_frame();
        test_abort();
        test_overrun();
        test_vsync_coincident();
        test_partial();
`ifdef SPI_ECHO_EN
        test_echo();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
